// File: rtl/spi_config_sequencer.sv
// spi_config_sequencer: two-requester round-robin front end that serialises
// 16-bit register write frames ({1, addr[6:0], data[7:0]}) onto SCLK/COPI/nCS
// slowly enough for a peripheral that oversamples through 2-flop synchronisers.
module spi_config_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int CS_LEAD = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       busy,
  output logic       grant_id,
  output logic       done,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic [7:0] LEAD_LAST = 8'(CS_LEAD - 1);
  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] frame_q, frame_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        ncs_q, ncs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        pick1_s;
  logic        any_valid_s;
  logic        accept_s;
  logic [3:0]  bit_idx_s;

  // Round-robin selection and combinational ready; only offered in IDLE out of reset.
  always_comb begin
    pick1_s     = 1'b0;
    any_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      pick1_s = ~last_grant_q;
    end else if (req1_valid) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
    if ((state_q == ST_IDLE) && !rst) begin
      req0_ready = any_valid_s & ~pick1_s;
      req1_ready = any_valid_s & pick1_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    accept_s = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  end

  // Frame sequencing: state, per-state cycle counter, bit counter, frame latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    frame_d      = frame_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d      = ST_LEAD;
          cnt_d        = 8'd0;
          bit_d        = 4'd0;
          grant_d      = pick1_s;
          last_grant_d = pick1_s;
          if (pick1_s) begin
            frame_d = {1'b1, req1_addr, req1_data};
          end else begin
            frame_d = {1'b1, req0_addr, req0_data};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (cnt_q == LEAD_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          // Wraps 15 -> 0 after the 16th high phase; LOW uses that as "last bit".
          state_d = ST_LOW;
          cnt_d   = 8'd0;
          bit_d   = bit_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_LOW: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = 8'd0;
          if (bit_q == 4'd0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Next-cycle pin values derived from the next state so the SPI pins are pure flops.
  always_comb begin
    ncs_d     = 1'b1;
    sclk_d    = 1'b0;
    copi_d    = 1'b0;
    bit_idx_s = 4'd15 - bit_d;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_GAP) && (state_q != ST_GAP);
    case (state_d)
      ST_LEAD: begin
        ncs_d  = 1'b0;
        copi_d = frame_d[bit_idx_s];
      end
      ST_HIGH: begin
        ncs_d  = 1'b0;
        sclk_d = 1'b1;
        copi_d = frame_d[bit_idx_s];
      end
      ST_LOW: begin
        ncs_d = 1'b0;
        if (bit_d == 4'd0) begin
          copi_d = frame_d[0];
        end else begin
          copi_d = frame_d[bit_idx_s];
        end
      end
      default: begin
        ncs_d  = 1'b1;
        copi_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      bit_q        <= 4'd0;
      frame_q      <= 16'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      sclk_q       <= 1'b0;
      copi_q       <= 1'b0;
      ncs_q        <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      frame_q      <= frame_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      sclk_q       <= sclk_d;
      copi_q       <= copi_d;
      ncs_q        <= ncs_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign SCLK     = sclk_q;
  assign COPI     = copi_q;
  assign nCS      = ncs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_spi_config_sequencer.sv
// Bench for spi_config_sequencer: requester queues plus an arbitration model
// predict each frame; an SPI sampler on the pins recovers what was sent.
module tb_spi_config_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [6:0] req0_addr = 7'd0, req1_addr = 7'd0;
  logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
  logic       busy, grant_id, done, SCLK, COPI, nCS;

  spi_config_sequencer dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .busy(busy), .grant_id(grant_id), .done(done), .SCLK(SCLK), .COPI(COPI), .nCS(nCS)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [14:0] q0[$];
  logic [14:0] q1[$];
  logic        last_m = 1'b1;
  int          prev_t0 = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    req0_addr  = (q0.size() > 0) ? q0[0][14:8] : 7'd0;
    req0_data  = (q0.size() > 0) ? q0[0][7:0]  : 8'd0;
    req1_addr  = (q1.size() > 0) ? q1[0][14:8] : 7'd0;
    req1_data  = (q1.size() > 0) ? q1[0][7:0]  : 8'd0;
  endtask

  // One whole frame: wait for accept, predict grantee, sample the SPI pins.
  task automatic do_frame(input string tag, input bit chk_gap);
    int          exp_g, rises, nlow, first_low, ndone, done_at, viol, t0;
    logic [15:0] exp_frame, cap;
    logic        ps, pc;
    bit          got;
    drive();
    got = 1'b0;
    for (int w = 0; w < 400 && !got; w++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got = 1'b1;
    end
    chk({tag, ":accept"}, 16'(got), 16'd1);
    if (!got) return;
    if (q0.size() > 0 && q1.size() > 0) exp_g = last_m ? 0 : 1;
    else if (q1.size() > 0)             exp_g = 1;
    else                                exp_g = 0;
    chk({tag, ":ready0"}, 16'(req0_ready), 16'(exp_g == 0));
    chk({tag, ":ready1"}, 16'(req1_ready), 16'(exp_g == 1));
    t0 = cyc;
    if (chk_gap) chk({tag, ":period"}, 16'(t0 - prev_t0), 16'd141);
    prev_t0   = t0;
    exp_frame = (exp_g == 1) ? {1'b1, q1[0]} : {1'b1, q0[0]};
    @(posedge clk); #1;
    if (exp_g == 1) void'(q1.pop_front()); else void'(q0.pop_front());
    last_m = (exp_g == 1);
    drive();
    rises = 0; nlow = 0; first_low = -1; ndone = 0; done_at = -1; viol = 0;
    cap = 16'd0; ps = 1'b0; pc = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      if (!nCS) begin
        nlow++;
        if (first_low < 0) first_low = k;
      end
      if (SCLK && !ps) begin
        rises++;
        cap = {cap[14:0], COPI};
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (!nCS && k > 1 && COPI !== pc && !(ps && !SCLK)) viol++;
      if (k == 1) begin
        chk({tag, ":grant_id"}, 16'(grant_id), 16'(exp_g));
        chk({tag, ":busy_start"}, 16'(busy), 16'd1);
        chk({tag, ":copi_lead"}, 16'(COPI), 16'(exp_frame[15]));
      end
      if (k == 70) chk({tag, ":ready_busy"}, 16'({req0_ready, req1_ready}), 16'd0);
      if (k == 140) chk({tag, ":busy_gap"}, 16'(busy), 16'd1);
      ps = SCLK;
      pc = COPI;
    end
    chk({tag, ":frame"}, cap, exp_frame);
    chk({tag, ":rises"}, 16'(rises), 16'd16);
    chk({tag, ":ncs_low"}, 16'(nlow), 16'd132);
    chk({tag, ":ncs_first"}, 16'(first_low), 16'd1);
    chk({tag, ":done_cnt"}, 16'(ndone), 16'd1);
    chk({tag, ":done_at"}, 16'(done_at), 16'd133);
    chk({tag, ":copi_stable"}, 16'(viol), 16'd0);
  endtask

  initial begin
    logic [14:0] r;
    int          rises, nd;
    logic        ps;
    bit          got;

    // Reset state, with a tie already pending so readys must stay low.
    q0.push_back({7'h00, 8'hAA});
    q1.push_back({7'h01, 8'h55});
    drive();
    repeat (3) @(negedge clk);
    chk("rst:nCS", 16'(nCS), 16'd1);
    chk("rst:SCLK", 16'(SCLK), 16'd0);
    chk("rst:COPI", 16'(COPI), 16'd0);
    chk("rst:busy", 16'(busy), 16'd0);
    chk("rst:done", 16'(done), 16'd0);
    chk("rst:grant_id", 16'(grant_id), 16'd0);
    chk("rst:ready", 16'({req0_ready, req1_ready}), 16'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Tie from reset: req0 first, then req1, back to back.
    do_frame("tie0", 1'b0);
    do_frame("tie1", 1'b1);

    // Single write 0x04/0x80 -> 0x8480.
    q0.push_back({7'h04, 8'h80});
    do_frame("single", 1'b1);

    // Fairness with both requesters continuously valid.
    for (int i = 0; i < 3; i++) begin
      r = 15'($urandom); q0.push_back(r);
      r = 15'($urandom); q1.push_back(r);
    end
    for (int i = 0; i < 6; i++) do_frame("fair", 1'b1);

    // Only req0 valid: granted every frame.
    for (int i = 0; i < 3; i++) begin
      r = 15'($urandom); q0.push_back(r);
    end
    for (int i = 0; i < 3; i++) do_frame("solo0", 1'b1);

    // Out-of-map address is still sent verbatim.
    q1.push_back({7'h7F, 8'hFF});
    do_frame("addr7f", 1'b1);

    // Reset after the 7th SCLK rise abandons the frame silently.
    r = 15'($urandom);
    q0.push_back(r);
    drive();
    got = 1'b0;
    for (int w = 0; w < 400 && !got; w++) begin
      @(negedge clk);
      if (req0_ready) got = 1'b1;
    end
    chk("midrst:accept", 16'(got), 16'd1);
    @(posedge clk); #1;
    void'(q0.pop_front());
    drive();
    rises = 0; ps = 1'b0;
    for (int k = 0; k < 200 && rises < 7; k++) begin
      @(negedge clk);
      if (SCLK && !ps) rises++;
      ps = SCLK;
    end
    chk("midrst:rises", 16'(rises), 16'd7);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst:nCS", 16'(nCS), 16'd1);
    chk("midrst:SCLK", 16'(SCLK), 16'd0);
    chk("midrst:COPI", 16'(COPI), 16'd0);
    chk("midrst:busy", 16'(busy), 16'd0);
    nd = 0;
    repeat (20) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("midrst:no_done", 16'(nd), 16'd0);
    last_m = 1'b1;
    q0.push_back({7'h02, 8'h0F});
    do_frame("after_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
